// File: rtl/shake_hand_arb_if.sv
// Handshake bundle between the local producers, the round-robin arbiter and the receiver.
interface shake_hand_arb_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic           ack_in;
  logic           ready_out;
  logic [W-1:0]   dout;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           err;
  logic           busy;

  // Arbiter side
  modport master (
    input  req, din, ack_in,
    output ready_out, dout, gnt, done, err, busy
  );

  // Producer/receiver side
  modport slave (
    output req, din, ack_in,
    input  ready_out, dout, gnt, done, err, busy
  );
endinterface

// File: rtl/shake_hand_arb.sv
// Round-robin arbiter sharing one 4-phase ready/ack receiver link among N channels.
module shake_hand_arb #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned TMO = 255
) (
  input logic               clk,
  input logic               rst,
  shake_hand_arb_if.master  bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  state_t        state;
  logic          ack_m;
  logic          ack_s;
  logic [IW-1:0] last;
  logic [IW-1:0] sel;
  logic [CW-1:0] cnt;

  logic [W-1:0]  words [N];
  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic [W-1:0]  win_data;

  // Split the flat data bus into per-channel words
  for (genvar g = 0; g < N; g++) begin : g_words
    assign words[g] = bus.din[g*W +: W];
  end

  // Round-robin search starting one past the last served channel
  always_comb begin
    logic [IW-1:0] c;
    c        = '0;
    win_vld  = 1'b0;
    win_idx  = '0;
    win_data = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      c = IW'((32'(last) + k) % N);
      if (!win_vld && bus.req[c]) begin
        win_vld  = 1'b1;
        win_idx  = c;
        win_data = words[c];
      end
    end
  end

  // Two-flop synchroniser for the receiver's ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= bus.ack_in;
      ack_s <= ack_m;
    end
  end

  // Arbitration and handshake FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last          <= IW'(N - 1);
      sel           <= '0;
      cnt           <= '0;
      bus.ready_out <= 1'b0;
      bus.dout      <= '0;
      bus.gnt       <= '0;
      bus.done      <= '0;
      bus.err       <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.done <= '0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          bus.gnt <= '0;
          if (win_vld) begin
            sel      <= win_idx;
            bus.gnt  <= N'(1) << win_idx;
            bus.dout <= win_data;
            bus.busy <= 1'b1;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_s) begin
            bus.ready_out <= 1'b1;
            cnt           <= '0;
            state         <= WAIT_DROP;
          end
        end
        WAIT_DROP: begin
          if (!ack_s) begin
            bus.ready_out <= 1'b0;
            bus.gnt       <= '0;
            bus.done      <= N'(1) << sel;
            bus.busy      <= 1'b0;
            last          <= sel;
            state         <= IDLE;
          end else if (cnt == CW'(TMO)) begin
            // Stuck receiver: abort and rotate past this channel
            bus.ready_out <= 1'b0;
            bus.gnt       <= '0;
            bus.err       <= 1'b1;
            bus.busy      <= 1'b0;
            last          <= sel;
            state         <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shake_hand_arb.sv
// Directed bench for shake_hand_arb: vector table of transfers plus timing sequences.
module tb_shake_hand_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned TMO = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shake_hand_arb_if #(.N(N), .W(W)) sif ();

  shake_hand_arb #(.N(N), .W(W), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  // Receiver model: 0 = ack low, 1 = normal 4-phase, 2 = ack stuck high
  int         rx_mode = 0;
  logic [7:0] rx_data = '0;

  always @(posedge clk) begin
    #2;
    case (rx_mode)
      0: sif.ack_in = 1'b0;
      1: begin
        if (sif.ack_in && sif.ready_out) begin
          rx_data    = sif.dout;
          sif.ack_in = 1'b0;
        end else if (!sif.ack_in && !sif.ready_out) begin
          sif.ack_in = 1'b1;
        end
      end
      default: sif.ack_in = 1'b1;
    endcase
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [7:0]  dout;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock step; sample after the edge and run the always-true checks
  task automatic tick();
    @(posedge clk);
    #1;
    if (sif.done != '0) done_cnt++;
    if (sif.err) err_cnt++;
    chk("gnt_onehot", 32'($countones(sif.gnt) <= 1), 32'd1);
    chk("busy_vs_gnt", 32'(sif.busy), 32'(sif.gnt != '0));
  endtask

  // Step until done pulses (bounded); grant must stay on hold_gnt meanwhile
  task automatic wait_done(input logic [3:0] hold_gnt);
    int n;
    n = 0;
    while (sif.done == '0 && n < 40) begin
      tick();
      n++;
      if (sif.done == '0) chk("gnt_hold", 32'(sif.gnt), 32'(hold_gnt));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    int n;

    vecs[0] = '{4'b1111, 32'h44332211, 4'b0001, 8'h11};
    vecs[1] = '{4'b1111, 32'h44332211, 4'b0010, 8'h22};
    vecs[2] = '{4'b1111, 32'h44332211, 4'b0100, 8'h33};
    vecs[3] = '{4'b1111, 32'h44332211, 4'b1000, 8'h44};
    vecs[4] = '{4'b1111, 32'h44332211, 4'b0001, 8'h11};
    vecs[5] = '{4'b0001, 32'h000000A5, 4'b0001, 8'hA5};
    vecs[6] = '{4'b0100, 32'h00770000, 4'b0100, 8'h77};
    vecs[7] = '{4'b0101, 32'h00EE00DD, 4'b0001, 8'hDD};
    vecs[8] = '{4'b0101, 32'h00EE00DD, 4'b0100, 8'hEE};

    sif.req = '0;
    sif.din = '0;
    tick();
    tick();
    chk("rst_ready", 32'(sif.ready_out), 32'd0);
    chk("rst_dout", 32'(sif.dout), 32'd0);
    chk("rst_gnt", 32'(sif.gnt), 32'd0);
    chk("rst_done", 32'(sif.done), 32'd0);
    chk("rst_err", 32'(sif.err), 32'd0);
    chk("rst_busy", 32'(sif.busy), 32'd0);
    rst = 1'b0;
    rx_mode = 1;
    repeat (3) tick();

    // Table: round robin, single request, fairness after a win
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 9; i++) begin
      sif.req = vecs[i].req;
      sif.din = vecs[i].din;
      tick();
      chk("vec_gnt", 32'(sif.gnt), 32'(vecs[i].gnt));
      chk("vec_dout", 32'(sif.dout), 32'(vecs[i].dout));
      chk("vec_ready_low", 32'(sif.ready_out), 32'd0);
      wait_done(vecs[i].gnt);
      chk("vec_done", 32'(sif.done), 32'(vecs[i].gnt));
      chk("vec_err", 32'(sif.err), 32'd0);
      chk("vec_ready_fall", 32'(sif.ready_out), 32'd0);
      chk("vec_rx_data", 32'(rx_data), 32'(vecs[i].dout));
      sif.req = '0;
      tick();
      chk("vec_done_pulse", 32'(sif.done), 32'd0);
      chk("vec_idle_busy", 32'(sif.busy), 32'd0);
      chk("vec_dout_hold", 32'(sif.dout), 32'(vecs[i].dout));
    end
    chk("table_done_count", 32'(done_cnt - d0), 32'd9);
    chk("table_err_count", 32'(err_cnt - e0), 32'd0);

    // Ack-to-ready latency and timeout with ack stuck high
    rx_mode = 0;
    repeat (4) tick();
    sif.req = 4'b1010;
    sif.din = 32'hC3005A00;
    tick();
    chk("tmo_gnt", 32'(sif.gnt), 32'b1000);
    chk("tmo_dout", 32'(sif.dout), 32'hC3);
    rx_mode = 2;
    d0 = done_cnt;
    e0 = err_cnt;
    tick();
    chk("ack_lat_1", 32'(sif.ready_out), 32'd0);
    tick();
    chk("ack_lat_2", 32'(sif.ready_out), 32'd0);
    tick();
    chk("ack_lat_3", 32'(sif.ready_out), 32'd1);
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k < 11) begin
        chk("tmo_ready_held", 32'(sif.ready_out), 32'd1);
        chk("tmo_err_early", 32'(sif.err), 32'd0);
      end else begin
        chk("tmo_ready_drop", 32'(sif.ready_out), 32'd0);
        chk("tmo_err", 32'(sif.err), 32'd1);
        chk("tmo_gnt_clr", 32'(sif.gnt), 32'd0);
        chk("tmo_no_done", 32'(sif.done), 32'd0);
      end
    end
    sif.req = 4'b0010;
    rx_mode = 1;
    tick();
    chk("tmo_next_gnt", 32'(sif.gnt), 32'b0010);
    chk("tmo_next_dout", 32'(sif.dout), 32'h5A);
    wait_done(4'b0010);
    chk("tmo_next_done", 32'(sif.done), 32'b0010);
    chk("tmo_next_rx", 32'(rx_data), 32'h5A);
    sif.req = '0;
    tick();
    chk("tmo_err_once", 32'(err_cnt - e0), 32'd1);
    chk("tmo_done_once", 32'(done_cnt - d0), 32'd1);

    // Request raised while busy, granted channel drops its request
    rx_mode = 0;
    repeat (4) tick();
    sif.req = 4'b0010;
    tick();
    chk("busy_gnt1", 32'(sif.gnt), 32'b0010);
    chk("busy_dout1", 32'(sif.dout), 32'h5A);
    sif.req = 4'b1000;
    rx_mode = 1;
    wait_done(4'b0010);
    chk("busy_done1", 32'(sif.done), 32'b0010);
    chk("busy_rx1", 32'(rx_data), 32'h5A);
    tick();
    chk("busy_gnt3", 32'(sif.gnt), 32'b1000);
    chk("busy_dout3", 32'(sif.dout), 32'hC3);
    wait_done(4'b1000);
    chk("busy_done3", 32'(sif.done), 32'b1000);
    chk("busy_rx3", 32'(rx_data), 32'hC3);
    sif.req = '0;
    tick();

    // Asynchronous reset in WAIT_DROP
    rx_mode = 0;
    repeat (4) tick();
    sif.req = 4'b0100;
    sif.din = 32'h009900AB;
    tick();
    chk("mid_gnt", 32'(sif.gnt), 32'b0100);
    rx_mode = 2;
    n = 0;
    while (!sif.ready_out && n < 10) begin
      tick();
      n++;
    end
    chk("mid_ready", 32'(sif.ready_out), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(sif.ready_out), 32'd0);
    chk("mid_rst_dout", 32'(sif.dout), 32'd0);
    chk("mid_rst_gnt", 32'(sif.gnt), 32'd0);
    chk("mid_rst_done", 32'(sif.done), 32'd0);
    chk("mid_rst_err", 32'(sif.err), 32'd0);
    chk("mid_rst_busy", 32'(sif.busy), 32'd0);
    rx_mode = 0;
    sif.req = 4'b0011;
    tick();
    chk("mid_rst_hold_gnt", 32'(sif.gnt), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_gnt", 32'(sif.gnt), 32'b0001);
    chk("post_rst_dout", 32'(sif.dout), 32'hAB);
    chk("post_rst_busy", 32'(sif.busy), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
